// File: rtl/uart_tx_fifo_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_fifo_if
// Description : Producer-side and transmitter-side handshake bundle for
//               uart_tx_fifo. The master modport is the producer/transmitter
//               environment; the slave modport is the FIFO block itself.
//               sent_count exists only when UART_TX_FIFO_STATS_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_tx_fifo_if #(
  parameter int ADDR_W = 4
);
  logic [7:0]      wr_data;
  logic            wr_en;
  logic            full;
  logic            empty;
  logic [ADDR_W:0] level;
  logic            overflow;
  logic            tx_err;
  logic [7:0]      data_in;
  logic            send;
  logic            busy;
`ifdef UART_TX_FIFO_STATS_EN
  logic [15:0]     sent_count;
`endif

  modport slave (
    input  wr_data, wr_en, busy,
    output full, empty, level, overflow, tx_err, data_in, send
`ifdef UART_TX_FIFO_STATS_EN
    , output sent_count
`endif
  );

  modport master (
    output wr_data, wr_en, busy,
    input  full, empty, level, overflow, tx_err, data_in, send
`ifdef UART_TX_FIFO_STATS_EN
    , input sent_count
`endif
  );
endinterface
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_fifo
// Description : Circular byte FIFO feeding a UART transmitter through its
//               data_in/send/busy handshake. Bytes are launched one at a
//               time; a missing busy response is flagged as tx_err.
//               Optional launch counter enabled by UART_TX_FIFO_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
  parameter int DEPTH        = 16,
  parameter int ADDR_W       = 4,
  parameter int BUSY_TIMEOUT = 8
) (
  input  wire logic        clk,
  input  wire logic        rst,
  uart_tx_fifo_if.slave    bus
);

  localparam logic [ADDR_W:0] FULL_LEVEL = (ADDR_W + 1)'(DEPTH);
  localparam logic [7:0]      TMO_LAST   = 8'(BUSY_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [7:0]       mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]  level;
  logic [7:0]       tmo_cnt;
  logic             tmo_hit;
  logic             overflow;
  logic             tx_err;
  logic [7:0]       data_in;
  logic             full;
  logic             empty;
  logic             wr_accept;
  logic             pop;

  // Flags come from the registered level so a pop cannot admit a same-cycle write when full.
  assign full      = (level == FULL_LEVEL);
  assign empty     = (level == '0);
  assign wr_accept = bus.wr_en && !full;
  assign pop       = (state == LAUNCH);

  // Storage array; contents need no reset since level gates every read.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem[wr_ptr] <= bus.wr_data;
    end
  end

  // Pointers, occupancy and overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_accept) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({wr_accept, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      if (bus.wr_en && full) begin
        overflow <= 1'b1;
      end
    end
  end

  // State register, busy timeout counter, launch data and error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      tmo_cnt <= '0;
      data_in <= 8'h00;
      tx_err  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == LAUNCH) begin
        tmo_cnt <= '0;
      end else if (state == WAIT_BUSY && !bus.busy) begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end
      // Capture the head byte as we enter LAUNCH so it is valid alongside send.
      if (state == IDLE && state_nxt == LAUNCH) begin
        data_in <= mem[rd_ptr];
      end
      if (tmo_hit) begin
        tx_err <= 1'b1;
      end
    end
  end

  // Next-state decode for the launch handshake.
  always_comb begin
    state_nxt = state;
    tmo_hit   = 1'b0;
    case (state)
      IDLE: begin
        if (!empty && !bus.busy) begin
          state_nxt = LAUNCH;
        end
      end
      LAUNCH: begin
        state_nxt = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (bus.busy) begin
          state_nxt = WAIT_DONE;
        end else if (tmo_cnt == TMO_LAST) begin
          // Transmitter never responded; the byte is treated as consumed.
          tmo_hit   = 1'b1;
          state_nxt = IDLE;
        end
      end
      WAIT_DONE: begin
        if (!bus.busy) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

`ifdef UART_TX_FIFO_STATS_EN
  logic [15:0] sent_count;

  // Launch counter, wraps naturally at 16 bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      sent_count <= 16'h0000;
    end else if (state == LAUNCH) begin
      sent_count <= sent_count + 1'b1;
    end
  end

  assign bus.sent_count = sent_count;
`endif

  assign bus.full     = full;
  assign bus.empty    = empty;
  assign bus.level    = level;
  assign bus.overflow = overflow;
  assign bus.tx_err   = tx_err;
  assign bus.data_in  = data_in;
  assign bus.send     = (state == LAUNCH);

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_fifo
// Description : Directed self-checking bench for uart_tx_fifo with a small
//               behavioural transmitter stub driving busy.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_fifo;

  localparam int FRAME = 12;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  uart_tx_fifo_if #(.ADDR_W(4)) bus ();

  uart_tx_fifo #(
    .DEPTH(16),
    .ADDR_W(4),
    .BUSY_TIMEOUT(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Transmitter stub: 0 = responds to send with a FRAME-long busy, 1 = busy stuck high, 2 = busy stuck low.
  int stub_mode = 0;
  int stub_cnt  = 0;
  always @(posedge clk) begin
    if (stub_mode == 1) begin
      bus.busy <= 1'b1;
    end else if (stub_mode == 2) begin
      bus.busy <= 1'b0;
    end else if (bus.send === 1'b1) begin
      bus.busy <= 1'b1;
      stub_cnt <= FRAME;
    end else if (stub_cnt > 1) begin
      stub_cnt <= stub_cnt - 1;
    end else begin
      stub_cnt <= 0;
      bus.busy <= 1'b0;
    end
  end

  // Launch monitor: records launched bytes and protocol violations.
  logic [7:0] mon_q[$];
  logic       prev_send   = 1'b0;
  int         viol_busy   = 0;
  int         viol_double = 0;
  always @(negedge clk) begin
    if (bus.send === 1'b1) begin
      mon_q.push_back(bus.data_in);
      if (bus.busy === 1'b1) viol_busy++;
      if (prev_send) viol_double++;
    end
    prev_send = (bus.send === 1'b1);
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.wr_en = 1'b0;
    bus.wr_data = 8'h00;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    mon_q.delete();
    viol_busy = 0;
    viol_double = 0;
  endtask

  task automatic wait_launches(input int n, input int budget, output bit timed_out);
    int b;
    b = budget;
    while (mon_q.size() < n && b > 0) begin
      @(negedge clk);
      b--;
    end
    timed_out = (mon_q.size() < n);
  endtask

  task automatic test_reset();
    stub_mode = 0;
    do_reset();
    checks++; if (bus.full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b want=0", bus.full); end
    checks++; if (bus.empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b want=1", bus.empty); end
    checks++; if (bus.level !== 5'd0) begin failures++; $display("FAIL reset_level got=%0d want=0", bus.level); end
    checks++; if (bus.overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b want=0", bus.overflow); end
    checks++; if (bus.tx_err !== 1'b0) begin failures++; $display("FAIL reset_tx_err got=%b want=0", bus.tx_err); end
    checks++; if (bus.data_in !== 8'h00) begin failures++; $display("FAIL reset_data_in got=%h want=00", bus.data_in); end
    checks++; if (bus.send !== 1'b0) begin failures++; $display("FAIL reset_send got=%b want=0", bus.send); end
`ifdef UART_TX_FIFO_STATS_EN
    checks++; if (bus.sent_count !== 16'd0) begin failures++; $display("FAIL reset_sent_count got=%0d want=0", bus.sent_count); end
`endif
  endtask

  task automatic test_single();
    @(negedge clk);
    bus.wr_data = 8'hA5;
    bus.wr_en = 1'b1;
    @(negedge clk);
    bus.wr_en = 1'b0;
    checks++; if (bus.level !== 5'd1) begin failures++; $display("FAIL single_level got=%0d want=1", bus.level); end
    checks++; if (bus.send !== 1'b0) begin failures++; $display("FAIL single_send_early got=%b want=0", bus.send); end
    @(negedge clk);
    checks++; if (bus.send !== 1'b1) begin failures++; $display("FAIL single_send got=%b want=1", bus.send); end
    checks++; if (bus.data_in !== 8'hA5) begin failures++; $display("FAIL single_data got=%h want=a5", bus.data_in); end
    @(negedge clk);
    checks++; if (bus.send !== 1'b0) begin failures++; $display("FAIL single_send_fall got=%b want=0", bus.send); end
    repeat (25) @(negedge clk);
    checks++; if (bus.empty !== 1'b1) begin failures++; $display("FAIL single_empty got=%b want=1", bus.empty); end
    checks++; if (bus.data_in !== 8'hA5) begin failures++; $display("FAIL single_data_hold got=%h want=a5", bus.data_in); end
    checks++; if (mon_q.size() !== 1) begin failures++; $display("FAIL single_launch_count got=%0d want=1", mon_q.size()); end
  endtask

  task automatic test_burst();
    int peak;
    bit to;
    do_reset();
    peak = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (int'(bus.level) > peak) peak = int'(bus.level);
      bus.wr_en = 1'b1;
      bus.wr_data = 8'(i + 1);
    end
    @(negedge clk);
    if (int'(bus.level) > peak) peak = int'(bus.level);
    bus.wr_en = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (int'(bus.level) > peak) peak = int'(bus.level);
    end
    wait_launches(3, 200, to);
    repeat (25) @(negedge clk);
    checks++; if (to) begin failures++; $display("FAIL burst_timeout got=%0d launches want=3", mon_q.size()); end
    checks++; if (peak !== 2) begin failures++; $display("FAIL burst_peak got=%0d want=2", peak); end
    checks++; if (mon_q.size() !== 3) begin failures++; $display("FAIL burst_count got=%0d want=3", mon_q.size()); end
    else begin
      checks++; if (mon_q[0] !== 8'h01 || mon_q[1] !== 8'h02 || mon_q[2] !== 8'h03) begin
        failures++; $display("FAIL burst_order got=%h,%h,%h want=01,02,03", mon_q[0], mon_q[1], mon_q[2]);
      end
    end
    checks++; if (viol_busy !== 0) begin failures++; $display("FAIL burst_send_while_busy got=%0d want=0", viol_busy); end
    checks++; if (viol_double !== 0) begin failures++; $display("FAIL burst_double_send got=%0d want=0", viol_double); end
`ifdef UART_TX_FIFO_STATS_EN
    checks++; if (bus.sent_count !== 16'd3) begin failures++; $display("FAIL burst_sent_count got=%0d want=3", bus.sent_count); end
`endif
  endtask

  task automatic test_overflow();
    bit to;
    int bad;
    do_reset();
    stub_mode = 1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      if (i == 15) begin
        checks++; if (bus.full !== 1'b0) begin failures++; $display("FAIL ovf_full_at15 got=%b want=0", bus.full); end
      end
      if (i == 16) begin
        checks++; if (bus.full !== 1'b1) begin failures++; $display("FAIL ovf_full got=%b want=1", bus.full); end
        checks++; if (bus.level !== 5'd16) begin failures++; $display("FAIL ovf_level got=%0d want=16", bus.level); end
        checks++; if (bus.overflow !== 1'b0) begin failures++; $display("FAIL ovf_flag_early got=%b want=0", bus.overflow); end
      end
      bus.wr_en = 1'b1;
      bus.wr_data = 8'(8'h10 + i);
    end
    @(negedge clk);
    bus.wr_en = 1'b0;
    checks++; if (bus.overflow !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%b want=1", bus.overflow); end
    checks++; if (bus.level !== 5'd16) begin failures++; $display("FAIL ovf_level_after got=%0d want=16", bus.level); end
    stub_mode = 0;
    wait_launches(16, 600, to);
    repeat (60) @(negedge clk);
    checks++; if (to) begin failures++; $display("FAIL ovf_drain_timeout got=%0d launches want=16", mon_q.size()); end
    checks++; if (mon_q.size() !== 16) begin failures++; $display("FAIL ovf_drain_count got=%0d want=16", mon_q.size()); end
    bad = 0;
    for (int i = 0; i < mon_q.size() && i < 16; i++) begin
      if (mon_q[i] !== 8'(8'h10 + i)) bad++;
    end
    checks++; if (bad !== 0) begin failures++; $display("FAIL ovf_drain_order got=%0d wrong bytes want=0", bad); end
    checks++; if (bus.empty !== 1'b1) begin failures++; $display("FAIL ovf_empty got=%b want=1", bus.empty); end
    checks++; if (bus.overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%b want=1", bus.overflow); end
  endtask

  task automatic test_timeout();
    int b;
    bit to;
    do_reset();
    stub_mode = 2;
    @(negedge clk);
    bus.wr_data = 8'h5A;
    bus.wr_en = 1'b1;
    @(negedge clk);
    bus.wr_en = 1'b0;
    b = 10;
    while (bus.send !== 1'b1 && b > 0) begin
      @(negedge clk);
      b--;
    end
    checks++; if (bus.send !== 1'b1 || bus.data_in !== 8'h5A) begin
      failures++; $display("FAIL tmo_launch got send=%b data=%h want send=1 data=5a", bus.send, bus.data_in);
    end
    repeat (7) @(negedge clk);
    checks++; if (bus.tx_err !== 1'b0) begin failures++; $display("FAIL tmo_err_early got=%b want=0", bus.tx_err); end
    repeat (3) @(negedge clk);
    checks++; if (bus.tx_err !== 1'b1) begin failures++; $display("FAIL tmo_err got=%b want=1", bus.tx_err); end
    checks++; if (bus.empty !== 1'b1) begin failures++; $display("FAIL tmo_consumed got=%b want=1", bus.empty); end
    stub_mode = 0;
    @(negedge clk);
    bus.wr_data = 8'h66;
    bus.wr_en = 1'b1;
    @(negedge clk);
    bus.wr_en = 1'b0;
    wait_launches(2, 50, to);
    repeat (25) @(negedge clk);
    checks++; if (to || mon_q.size() != 2) begin failures++; $display("FAIL tmo_next_launch got=%0d launches want=2", mon_q.size()); end
    else begin
      checks++; if (mon_q[1] !== 8'h66) begin failures++; $display("FAIL tmo_next_data got=%h want=66", mon_q[1]); end
    end
    checks++; if (bus.tx_err !== 1'b1) begin failures++; $display("FAIL tmo_sticky got=%b want=1", bus.tx_err); end
`ifdef UART_TX_FIFO_STATS_EN
    checks++; if (bus.sent_count !== 16'd2) begin failures++; $display("FAIL tmo_sent_count got=%0d want=2", bus.sent_count); end
`endif
  endtask

  task automatic test_wrap();
    bit to;
    int bad;
    int bad_level;
    do_reset();
    stub_mode = 0;
    bad_level = 0;
    to = 1'b0;
    for (int g = 0; g < 4; g++) begin
      bit gto;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        bus.wr_en = 1'b1;
        bus.wr_data = 8'(g * 10 + i);
      end
      @(negedge clk);
      bus.wr_en = 1'b0;
      if (bus.level !== 5'd9) bad_level++;
      wait_launches(10 * (g + 1), 400, gto);
      if (gto) to = 1'b1;
      repeat (25) @(negedge clk);
      if (bus.level !== 5'd0) bad_level++;
    end
    checks++; if (to) begin failures++; $display("FAIL wrap_timeout got=%0d launches want=40", mon_q.size()); end
    checks++; if (bad_level !== 0) begin failures++; $display("FAIL wrap_level got=%0d bad samples want=0", bad_level); end
    checks++; if (mon_q.size() !== 40) begin failures++; $display("FAIL wrap_count got=%0d want=40", mon_q.size()); end
    bad = 0;
    for (int i = 0; i < mon_q.size() && i < 40; i++) begin
      if (mon_q[i] !== 8'(i)) bad++;
    end
    checks++; if (bad !== 0) begin failures++; $display("FAIL wrap_order got=%0d wrong bytes want=0", bad); end
    checks++; if (viol_busy !== 0 || viol_double !== 0) begin
      failures++; $display("FAIL wrap_protocol got busy_viol=%0d double=%0d want=0,0", viol_busy, viol_double);
    end
  endtask

  task automatic test_reset_mid();
    bit to;
    int n;
    do_reset();
    stub_mode = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.wr_en = 1'b1;
      bus.wr_data = 8'(8'hA0 + i);
    end
    @(negedge clk);
    bus.wr_en = 1'b0;
    wait_launches(1, 20, to);
    repeat (4) @(negedge clk);
    checks++; if (to || bus.busy !== 1'b1) begin failures++; $display("FAIL mid_setup got busy=%b launches=%0d want busy=1", bus.busy, mon_q.size()); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (bus.level !== 5'd0 || bus.empty !== 1'b1 || bus.full !== 1'b0) begin
      failures++; $display("FAIL mid_fifo got level=%0d empty=%b full=%b want 0,1,0", bus.level, bus.empty, bus.full);
    end
    checks++; if (bus.send !== 1'b0 || bus.data_in !== 8'h00) begin
      failures++; $display("FAIL mid_tx got send=%b data=%h want 0,00", bus.send, bus.data_in);
    end
    checks++; if (bus.overflow !== 1'b0 || bus.tx_err !== 1'b0) begin
      failures++; $display("FAIL mid_flags got ovf=%b err=%b want 0,0", bus.overflow, bus.tx_err);
    end
`ifdef UART_TX_FIFO_STATS_EN
    checks++; if (bus.sent_count !== 16'd0) begin failures++; $display("FAIL mid_sent_count got=%0d want=0", bus.sent_count); end
`endif
    n = mon_q.size();
    repeat (60) @(negedge clk);
    checks++; if (mon_q.size() !== n) begin failures++; $display("FAIL mid_no_send got=%0d launches want=%0d", mon_q.size(), n); end
  endtask

  initial begin
    bus.wr_en = 1'b0;
    bus.wr_data = 8'h00;
    test_reset();
    test_single();
    test_burst();
    test_overflow();
    test_timeout();
    test_wrap();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Transmit-side byte buffer that sits directly upstream of `uart_top`. It accepts bytes from a producer at full clock rate, stores them in a circular FIFO, and launches them one at a time into the UART transmitter through its `data_in`/`send`/`busy` handshake. Producers can queue bursts without tracking the 115200-baud (434 clocks/bit at 50 MHz) frame time.

## Interface
- `DEPTH`, 16: FIFO entries; power of two, 2 to 256.
- `ADDR_W`, 4: pointer width; equals log2(DEPTH).
- `BUSY_TIMEOUT`, 8: cycles to wait for `busy` to rise after `send`; 1 to 255.

- `clk`  in  1  system clock, 50 MHz.
- `rst`  in  1  synchronous, active-high reset.
- `wr_data`  in  8  byte to enqueue.
- `wr_en`  in  1  enqueue strobe; one byte per cycle when high.
- `full`  out  1  FIFO holds DEPTH entries.
- `empty`  out  1  FIFO holds 0 entries.
- `level`  out  ADDR_W+1  current entry count.
- `overflow`  out  1  sticky; a write was attempted while full.
- `tx_err`  out  1  sticky; `busy` did not rise within BUSY_TIMEOUT.
- `data_in`  out  8  byte presented to `uart_top`; registered.
- `send`  out  1  one-cycle launch pulse to `uart_top`.
- `busy`  in  1  transmitter busy from `uart_top`.
- `sent_count`  out  16  bytes launched; present only with UART_TX_FIFO_STATS_EN.

## Operation
- Storage is DEPTH×8 memory with `wr_ptr`/`rd_ptr` (ADDR_W bits, natural wrap at DEPTH-1→0) and `level` counter.
- Write: `wr_en` && !`full` stores `wr_data` at `wr_ptr`, increments `wr_ptr`. `wr_en` && `full` drops the byte, sets `overflow`, and changes no pointer.
- `full`/`empty` are decoded from the registered `level`. A write in the same cycle as a pop while full is still dropped.
- Simultaneous accepted write and pop: `level` is unchanged and both pointers advance.
- The FSM has four states:
  - IDLE: when !`empty` && !`busy`, go to LAUNCH.
  - LAUNCH: one cycle. `send`=1, `data_in`←mem[`rd_ptr`], pop (`rd_ptr`++, `level`--). Go to WAIT_BUSY and clear the timeout counter.
  - WAIT_BUSY: if `busy`=1, go to WAIT_DONE. Otherwise increment the counter. When the counter reaches BUSY_TIMEOUT, set `tx_err` and go to IDLE; the byte is considered consumed.
  - WAIT_DONE: when `busy`=0, go to IDLE.
- `data_in` holds its value from LAUNCH until the next LAUNCH.
- Sticky flags clear only on `rst`.
- Reset mid-transfer: FIFO contents are discarded and the FSM returns to IDLE. The frame already in `uart_top` is not aborted by this block.

## Timing
- Reset values: `full`=0, `empty`=1, `level`=0, `overflow`=0, `tx_err`=0, `data_in`=8'h00, `send`=0, `sent_count`=0. Pointers are 0 and state is IDLE.
- Latency with empty FIFO, IDLE, and `busy`=0:
  - `wr_en` sampled at edge N gives `level`=1 after edge N.
  - State becomes LAUNCH after edge N+1, so `send`=1 and `data_in` are valid in the cycle after edge N+1.
  - `send` returns to 0 after edge N+2.
- `send` is never high for two consecutive cycles.
- Back-to-back bytes: the next LAUNCH comes no earlier than 2 cycles after `busy` falls.
- `level` never exceeds DEPTH and never goes below 0.

## Configuration
- UART_TX_FIFO_STATS_EN defined:
  - `sent_count` port exists.
  - It increments by 1 on every LAUNCH cycle, including launches that later time out.
  - It wraps from 16'hFFFF to 0.
- Undefined: the port and counter are absent, and all other behaviour is identical.

## Test plan
- Single byte, `uart_top` connected: write 8'hA5 → `send` pulses 1 cycle with `data_in`=8'hA5. The tx line shows start, bits 1,0,1,0,0,1,0,1 (LSB first), then stop, at 434 clocks/bit. `empty`=1 afterwards.
- Burst: write 8'h01, 8'h02, 8'h03 on 3 consecutive cycles → `level` peaks at 2 (one byte already popped). Three frames go out in order with no `send` while `busy`=1. `sent_count`=3 when STATS_EN is defined.
- Overflow with DEPTH=16 and `busy` held high by a stub: write 17 bytes → `full`=1 after 16, the 17th is dropped, `overflow`=1. Releasing `busy` drains exactly 16 bytes.
- Timeout: stub holds `busy`=0, write 8'h5A → `send` pulse, then `tx_err`=1 after BUSY_TIMEOUT=8 cycles. FSM returns to IDLE and the next byte launches normally.
- Wrap: with DEPTH=16, write/drain 40 bytes 8'h00..8'h27 in groups of 10 → all emitted in order across pointer wrap, `level` correct throughout.
- Reset mid-transfer: queue 5 bytes, assert `rst` for 1 cycle during WAIT_DONE → all outputs take their reset values the next cycle and no further `send` occurs.
